// File: rtl/fht_pkg.sv
// rtl/fht_pkg.sv - shared defaults, FSM encoding and bit-reverse helper for the FHT address generator
package fht_pkg;

    localparam int N_POINT_DEF = 256;
    localparam int A_BIT_DEF   = 8;
    localparam int RD_LAT_DEF  = 1;
    localparam int BUT_LAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fht_state_e;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r[i] = v[w - 1 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_delay_line.sv
// rtl/fht_delay_line.sv - async-reset shift register aligning write side to butterfly outputs
module fht_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [WIDTH-1:0] iDATA,
    output logic [WIDTH-1:0] oDATA
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= iDATA;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign oDATA = pipe[DEPTH-1];

endmodule

// File: rtl/fht_addr_gen.sv
// rtl/fht_addr_gen.sv - per-stage FHT read/twiddle/write address sequencer, one butterfly per clock
// Define FHT_BITREV_EN to bit-reverse the stage-0 read addresses (input reorder).
module fht_addr_gen
    import fht_pkg::*;
#(
    parameter int N_POINT = 16,
    parameter int A_BIT   = 4,
    parameter int RD_LAT  = RD_LAT_DEF,
    parameter int BUT_LAT = BUT_LAT_DEF,
    localparam int S_BIT  = $clog2(A_BIT)
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic [S_BIT-1:0] iSTAGE,
    output logic [A_BIT-1:0] oRD_ADDR_0,
    output logic [A_BIT-1:0] oRD_ADDR_1,
    output logic [A_BIT-1:0] oRD_ADDR_2,
    output logic [A_BIT-2:0] oROM_ADDR,
    output logic             oRD_EN,
    output logic             oRD_BANK,
    output logic [A_BIT-1:0] oWR_ADDR_0,
    output logic [A_BIT-1:0] oWR_ADDR_1,
    output logic             oWE,
    output logic             oRDY,
    output logic             oDONE
);

    localparam int HALF_N = N_POINT / 2;
    localparam int LAT    = RD_LAT + BUT_LAT;
    localparam int D_BIT  = $clog2(LAT + 1);
    localparam int DL_W   = 2 * A_BIT + 1;

    fht_state_e       state, state_n;
    logic [A_BIT-2:0] b;
    logic [S_BIT-1:0] s;
    logic [D_BIT-1:0] drain_cnt;
    logic             rd_en_q, done_q, bank_q;
    logic [A_BIT-1:0] rd0_q, rd1_q, rd2_q, wr0_q, wr1_q;
    logic [A_BIT-2:0] rom_q;

    logic [A_BIT-1:0] bb, half, jj, base, x0, x1, x2, rd0, rd1, rd2;
    logic [A_BIT-2:0] rom;
    logic [S_BIT:0]   s_ext, rom_sh;
    logic             use_rev;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (iSTART) state_n = ST_RUN;
            ST_RUN:   if (b == (A_BIT-1)'(HALF_N - 1)) state_n = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == D_BIT'(LAT - 1)) state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Butterfly index math; everything wraps modulo 2^A_BIT.
    assign s_ext  = {1'b0, s};
    assign rom_sh = (S_BIT+1)'(A_BIT - 1) - s_ext;

    always_comb begin
        bb   = {1'b0, b};
        half = A_BIT'(1) << s;
        jj   = bb & (half - 1'b1);
        base = (bb >> s) << (s_ext + 1'b1);
        x0   = base + jj;
        x1   = base + half + jj;
        x2   = (jj == '0) ? base + half : base + (half << 1) - jj;
        rom  = (A_BIT-1)'(jj << rom_sh);
    end

`ifdef FHT_BITREV_EN
    assign use_rev = (s == '0);
`else
    assign use_rev = 1'b0;
`endif

    assign rd0 = use_rev ? A_BIT'(bitrev(32'(x0), A_BIT)) : x0;
    assign rd1 = use_rev ? A_BIT'(bitrev(32'(x1), A_BIT)) : x1;
    assign rd2 = use_rev ? A_BIT'(bitrev(32'(x2), A_BIT)) : x2;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            b         <= '0;
            s         <= '0;
            drain_cnt <= '0;
            rd_en_q   <= 1'b0;
            done_q    <= 1'b0;
            bank_q    <= 1'b0;
            rd0_q     <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            rom_q     <= '0;
            wr0_q     <= '0;
            wr1_q     <= '0;
        end else begin
            rd_en_q   <= (state == ST_RUN);
            done_q    <= (state == ST_DONE);
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
            if (state == ST_IDLE && iSTART) begin
                s      <= iSTAGE;
                b      <= '0;
                bank_q <= iSTAGE[0];
            end
            if (state == ST_RUN) begin
                b     <= b + 1'b1;
                rd0_q <= rd0;
                rd1_q <= rd1;
                rd2_q <= rd2;
                rom_q <= rom;
                // Writes always use natural order, even when reads are bit-reversed.
                wr0_q <= x0;
                wr1_q <= x1;
            end
        end
    end

    fht_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (LAT)
    ) u_delay (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iDATA  ({rd_en_q, wr0_q, wr1_q}),
        .oDATA  ({oWE, oWR_ADDR_0, oWR_ADDR_1})
    );

    assign oRD_ADDR_0 = rd0_q;
    assign oRD_ADDR_1 = rd1_q;
    assign oRD_ADDR_2 = rd2_q;
    assign oROM_ADDR  = rom_q;
    assign oRD_EN     = rd_en_q;
    assign oRD_BANK   = bank_q;
    assign oDONE      = done_q;
    assign oRDY       = (state == ST_IDLE);

endmodule

// File: tb/tb_fht_addr_gen.sv
// tb/tb_fht_addr_gen.sv - directed self-checking bench for fht_addr_gen at N_POINT=16
module tb_fht_addr_gen;

    localparam int N  = 16;
    localparam int AB = 4;
    localparam int SB = 2;

    logic          iCLK = 1'b0;
    logic          iRESET;
    logic          iSTART;
    logic [SB-1:0] iSTAGE;
    logic [AB-1:0] oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oWR_ADDR_0, oWR_ADDR_1;
    logic [AB-2:0] oROM_ADDR;
    logic          oRD_EN, oRD_BANK, oWE, oRDY, oDONE;

    int n_chk = 0;
    int n_pass = 0;
    int cnt_rd_en = 0;
    int cnt_we = 0;
    int cnt_done = 0;
    int cnt_rdy_low = 0;
    int wr_hits [N];

    fht_addr_gen #(
        .N_POINT (N),
        .A_BIT   (AB),
        .RD_LAT  (1),
        .BUT_LAT (2)
    ) dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iSTART     (iSTART),
        .iSTAGE     (iSTAGE),
        .oRD_ADDR_0 (oRD_ADDR_0),
        .oRD_ADDR_1 (oRD_ADDR_1),
        .oRD_ADDR_2 (oRD_ADDR_2),
        .oROM_ADDR  (oROM_ADDR),
        .oRD_EN     (oRD_EN),
        .oRD_BANK   (oRD_BANK),
        .oWR_ADDR_0 (oWR_ADDR_0),
        .oWR_ADDR_1 (oWR_ADDR_1),
        .oWE        (oWE),
        .oRDY       (oRDY),
        .oDONE      (oDONE)
    );

    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) begin
        if (oRD_EN) cnt_rd_en++;
        if (oDONE) cnt_done++;
        if (!oRDY) cnt_rdy_low++;
        if (oWE) begin
            cnt_we++;
            wr_hits[oWR_ADDR_0]++;
            wr_hits[oWR_ADDR_1]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_counts();
        cnt_rd_en = 0;
        cnt_we = 0;
        cnt_done = 0;
        cnt_rdy_low = 0;
        for (int a = 0; a < N; a++) wr_hits[a] = 0;
    endtask

    task automatic start_stage(input int st);
        iSTART = 1'b1;
        iSTAGE = SB'(st);
        @(negedge iCLK);
        iSTART = 1'b0;
    endtask

    task automatic wait_rd_en(input string tag);
        int n = 0;
        while (!oRD_EN && n < 64) begin
            @(negedge iCLK);
            n++;
        end
        chk({tag, "_rd_en_seen"}, oRD_EN, 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!oDONE && n < 64) begin
            @(negedge iCLK);
            n++;
        end
        chk({tag, "_done_seen"}, oDONE, 1);
    endtask

    task automatic chk_rd(input string tag, input int x0, input int x1, input int x2, input int rom);
        chk({tag, "_x0"}, oRD_ADDR_0, x0);
        chk({tag, "_x1"}, oRD_ADDR_1, x1);
        chk({tag, "_x2"}, oRD_ADDR_2, x2);
        chk({tag, "_rom"}, oROM_ADDR, rom);
    endtask

    initial begin
        int snap_we, snap_done, good;
        iRESET = 1'b0;
        iSTART = 1'b0;
        iSTAGE = '0;
        repeat (3) @(negedge iCLK);
        iRESET = 1'b1;
        @(negedge iCLK);

        chk("rst_rdy", oRDY, 1);
        chk("rst_rd_en", oRD_EN, 0);
        chk("rst_we", oWE, 0);
        chk("rst_done", oDONE, 0);
        chk("rst_bank", oRD_BANK, 0);
        chk("rst_rd0", oRD_ADDR_0, 0);
        chk("rst_wr1", oWR_ADDR_1, 0);

        // Stage 1: first three butterflies, write latency, totals.
        clear_counts();
        start_stage(1);
        chk("t1_rdy_busy", oRDY, 0);
        wait_rd_en("t1");
        chk_rd("t1_b0", 0, 2, 2, 0);
        chk("t1_bank", oRD_BANK, 1);
        @(negedge iCLK);
        chk_rd("t1_b1", 1, 3, 3, 4);
        @(negedge iCLK);
        chk_rd("t1_b2", 4, 6, 6, 0);
        chk("t1_we_early", oWE, 0);
        @(negedge iCLK);
        chk("t1_we_lat", oWE, 1);
        chk("t1_wr0_b0", oWR_ADDR_0, 0);
        chk("t1_wr1_b0", oWR_ADDR_1, 2);
        wait_done("t1");
        @(negedge iCLK);
        chk("t1_rd_en_cnt", cnt_rd_en, 8);
        chk("t1_we_cnt", cnt_we, 8);
        chk("t1_done_cnt", cnt_done, 1);

        // Stage 3: b=3 read and its write exactly three clocks later.
        start_stage(3);
        wait_rd_en("t2");
        repeat (3) @(negedge iCLK);
        chk_rd("t2_b3", 3, 11, 13, 3);
        repeat (2) @(negedge iCLK);
        chk("t2_wr0_b2", oWR_ADDR_0, 2);
        @(negedge iCLK);
        chk("t2_we", oWE, 1);
        chk("t2_wr0_b3", oWR_ADDR_0, 3);
        chk("t2_wr1_b3", oWR_ADDR_1, 11);
        wait_done("t2");
        @(negedge iCLK);

        // Stage 0: input reorder on reads only.
        start_stage(0);
        wait_rd_en("t3");
        @(negedge iCLK);
`ifdef FHT_BITREV_EN
        chk_rd("t3_b1", 4, 12, 12, 0);
`else
        chk_rd("t3_b1", 2, 3, 3, 0);
`endif
        chk("t3_bank", oRD_BANK, 0);
        repeat (3) @(negedge iCLK);
        chk("t3_wr0", oWR_ADDR_0, 2);
        chk("t3_wr1", oWR_ADDR_1, 3);
        wait_done("t3");
        @(negedge iCLK);

        // Stage 2 with a stray iSTART mid-run.
        clear_counts();
        start_stage(2);
        repeat (2) @(negedge iCLK);
        iSTART = 1'b1;
        iSTAGE = 2'd1;
        @(negedge iCLK);
        iSTART = 1'b0;
        chk("t4_rdy_mid", oRDY, 0);
        chk("t4_bank_mid", oRD_BANK, 0);
        wait_done("t4");
        @(negedge iCLK);
        chk("t4_rdy_low_cnt", cnt_rdy_low, 12);
        repeat (10) @(negedge iCLK);
        chk("t4_rd_en_cnt", cnt_rd_en, 8);
        chk("t4_done_cnt", cnt_done, 1);
        chk("t4_rdy_after", oRDY, 1);

        // Reset mid-stage at b=4.
        start_stage(1);
        wait_rd_en("t5");
        repeat (4) @(negedge iCLK);
        iRESET = 1'b0;
        #1;
        snap_we = cnt_we;
        snap_done = cnt_done;
        chk("t5_rdy", oRDY, 1);
        chk("t5_rd_en", oRD_EN, 0);
        chk("t5_we", oWE, 0);
        chk("t5_bank", oRD_BANK, 0);
        chk("t5_rd0", oRD_ADDR_0, 0);
        chk("t5_wr0", oWR_ADDR_0, 0);
        repeat (2) @(negedge iCLK);
        iRESET = 1'b1;
        repeat (10) @(negedge iCLK);
        chk("t5_no_we", cnt_we, snap_we);
        chk("t5_no_done", cnt_done, snap_done);
        clear_counts();
        start_stage(2);
        wait_done("t5_fresh");
        @(negedge iCLK);
        chk("t5_fresh_we", cnt_we, 8);
        chk("t5_fresh_done", cnt_done, 1);

        // Back-to-back stages 0..3.
        clear_counts();
        for (int st = 0; st < 4; st++) begin
            chk("t6_rdy", oRDY, 1);
            start_stage(st);
            wait_rd_en("t6");
            chk($sformatf("t6_bank_%0d", st), oRD_BANK, st & 1);
            wait_done("t6");
            good = 0;
            for (int a = 0; a < N; a++) begin
                if (wr_hits[a] == 1) good++;
                wr_hits[a] = 0;
            end
            chk($sformatf("t6_cover_%0d", st), good, N);
        end
        @(negedge iCLK);
        chk("t6_we_total", cnt_we, 32);
        chk("t6_done_total", cnt_done, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
